// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: opcodes, FSM state
// encoding and the rule for the carry that seeds the LSB slice.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ZERO = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_INC  = 3'b100,
    OP_SUB  = 3'b101,
    OP_ADD  = 3'b110,
    OP_ONES = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // INC adds one to b through the carry chain; SUB/ADD take the external carry.
  function automatic logic init_carry(op_e op, logic cin);
    case (op)
      OP_INC:         init_carry = 1'b1;
      OP_SUB, OP_ADD: init_carry = cin;
      default:        init_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial ALU.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, abort, sel, a, b, cin,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, abort, sel, a, b, cin,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice; purely combinational, chained through an external carry register.
import alu_ctrl_pkg::*;

module alu_bit_slice (
  input  op_e  sel,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic y,
  output logic cout
);

  logic b_inv;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    y     = 1'b0;
    cout  = 1'b0;
    b_inv = ~b;
    case (sel)
      OP_ZERO: y = 1'b0;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_INC: begin
        y    = b ^ cin;
        cout = b & cin;
      end
      OP_SUB: begin
        y    = a ^ b_inv ^ cin;
        cout = (a & b_inv) | (cin & (a ^ b_inv));
      end
      OP_ADD: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      OP_ONES: y = 1'b1;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: latches operands on start, runs one slice per
// cycle LSB first, then presents result/cout/zero with a one-cycle done pulse.
import alu_ctrl_pkg::*;

module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_serial_ctrl_if.slave  bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              sel_q, sel_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] y_sh_q, y_sh_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             slice_y;
  logic             slice_cout;
  logic [WIDTH-1:0] y_next;

  alu_bit_slice u_slice (
    .sel  (sel_q),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // The newest slice output enters at the top; after the last bit the
  // concatenation is the complete result in natural bit order.
  assign y_next = {slice_y, y_sh_q};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    y_sh_d   = y_sh_q;
    count_d  = count_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        // start takes priority over abort here; abort only matters in RUN.
        if (bus.start) begin
          sel_d   = op_e'(bus.sel);
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = init_carry(op_e'(bus.sel), bus.cin);
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          a_sh_d  = a_sh_q >> 1;
          b_sh_d  = b_sh_q >> 1;
          y_sh_d  = y_next[WIDTH-1:1];
          carry_d = slice_cout;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d  = ST_DONE;
            result_d = y_next;
            cout_d   = slice_cout;
            zero_d   = (y_next == '0);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers, including the operand shifters, reset to known values;
  // zero resets high because the reset result is all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= OP_ZERO;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      y_sh_q   <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      y_sh_q   <= y_sh_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 abort  input  1  cancel the operation in progress; synchronous.
REQ-006 sel  input  3  opcode: 000 zero, 001 AND, 010 OR, 011 XOR, 100 INC b, 101 SUB a+~b+cin, 110 ADD a+b+cin, 111 ones.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for SUB/ADD.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when result, cout and zero are updated.
REQ-012 result  output  WIDTH  registered result; held until the next done.
REQ-013 cout  output  1  registered carry-out of the final bit.
REQ-014 zero  output  1  registered flag, high when result is all zeros.

Function
REQ-015 The block SHALL compute the operation bit-serially, LSB first, using one 1-bit ALU slice per cycle.
REQ-016 FSM states SHALL be IDLE, RUN and DONE; there is no other state.
REQ-017 IDLE with start=1 at an edge: latch sel, a, b and the initial carry, clear the bit counter, go to RUN.
REQ-018 Initial carry SHALL be 1 for INC, cin for SUB/ADD, and 0 for all logic ops.
REQ-019 Each RUN edge SHALL process bit[count], shift y into the result shift register MSB-first, store the slice carry as the next carry, and increment count.
REQ-020 The RUN edge with count = WIDTH-1 SHALL go to DONE and load result, cout (the final slice carry) and zero.
REQ-021 Latency SHALL be fixed: with start sampled at edge 0, done is high for exactly the cycle after edge WIDTH.
REQ-022 DONE SHALL return to IDLE on the next edge unconditionally; start is not accepted in DONE.
REQ-023 Back-to-back operations SHALL therefore start at most once every WIDTH+2 cycles.
REQ-024 start while busy SHALL be ignored with no effect on state, operands or outputs.
REQ-025 cout SHALL be 0 for opcodes 000, 001, 010, 011 and 111.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH with the carry beyond the MSB reported on cout; for SUB, cout=1 means no borrow.
REQ-027 abort in RUN SHALL return to IDLE on that edge without asserting done and without changing result, cout or zero.
REQ-028 abort in IDLE or DONE SHALL have no effect; the DONE pulse still occurs.
REQ-029 abort and start high together in IDLE: start SHALL win.
REQ-030 Operand inputs SHALL NOT need to be held stable after the accepting edge.

Reset
REQ-031 rst_n low SHALL force IDLE, count 0, carry 0, result 0, cout 0, zero 1, busy 0 and done 0, all immediately.
REQ-032 Reset mid-operation SHALL discard the operation; no done pulse follows deassertion.
REQ-033 The first start SHALL be accepted on the first edge after rst_n deasserts.

Structure
REQ-034 A shared package alu_ctrl_pkg SHALL hold the opcode constants (OP_ZERO..OP_ONES) and the FSM state encoding.
REQ-035 The 1-bit datapath SHALL be a combinational sub-module alu_bit_slice with ports sel, a, b, cin, y and cout, instantiated once.
REQ-036 The shift registers, counter, carry register and FSM SHALL live in alu_serial_ctrl.

Verification
REQ-037 ADD: a=8'h7F, b=8'h01, cin=0 -> done at edge 8+1, result=8'h80, cout=0, zero=0.
REQ-038 SUB: a=8'h05, b=8'h07, cin=1 -> result=8'hFE, cout=0. ADD: a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1, zero=1.
REQ-039 INC: b=8'hFF, a=8'h00 -> result=8'h00, cout=1. XOR: a=8'hA5, b=8'h0F -> result=8'hAA, cout=0.
REQ-040 Second start with new operands during RUN and during DONE -> ignored; the first result is delivered and busy drops after DONE.
REQ-041 abort at the 4th RUN cycle -> IDLE next cycle, no done, previous result and cout held; a following start completes normally.
REQ-042 rst_n pulsed low mid-RUN -> outputs at reset values immediately, no done after release; opcode 111 afterwards -> result=8'hFF, cout=0.
